cache_fill_controller: RTL and testbench
========================================

// Module: cache_fill_controller
// PURPOSE
//  Miss-side partner of the direct-mapped cache. On a processor read that misses, it fetches the
//  aligned 4-word block from main memory one word at a time, then drives one cWrite pulse with
//  adr0..adr3/block0..block3 into the cache. Sits between the CPU request path, the cache hit line
//  and the memory read port; stalls the CPU until the refilled block is readable.
// PARAMETERS
//  WORD      32  data word width
//  ADDRESSL  12  cache index width
//  TAG       3   tag width; full address width ADDRW = ADDRESSL+TAG = 15
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  req        in   1      CPU read request, held with address until stall==0
//  address    in   ADDRW  CPU word address
//  hit        in   1      cache hit for address (combinational from cache)
//  stall      out  1      CPU must hold request
//  mem_rd     out  1      memory read request, held until mem_ready
//  mem_adr    out  ADDRW  memory word address
//  mem_ready  in   1      memory word valid on mem_data this cycle (completes mem_rd)
//  mem_data   in   WORD   memory read data
//  cWrite     out  1      one-cycle cache block write strobe
//  adr0..adr3 out  ADDRW  block word addresses: base+0..base+3
//  block0..3  out  WORD   fetched words, block<k> belongs to adr<k>
//  miss_count out  16     misses serviced (only with CACHE_MISS_COUNT_EN)
// BEHAVIOUR
//  Reset (rst==0, async): state IDLE, idx=0, base=0, block0..3=0, mem_rd=0, mem_adr=0, cWrite=0,
//   miss_count=0; stall follows its equation (0 unless req&&!hit). Reset mid-fetch abandons the
//   block; no cWrite is issued.
//  States: IDLE -> FETCH -> FILL -> IDLE.
//  IDLE: stall = req && !hit (combinational). If req && !hit at posedge: base <= {address[ADDRW-1:2],2'b00},
//   idx <= 0, go FETCH. req&&hit: no action, stall=0. mem_ready in IDLE is ignored.
//  FETCH: stall=1, mem_rd=1, mem_adr=base+idx (registered). At posedge with mem_ready:
//   block<idx> <= mem_data; if idx==3 go FILL (mem_rd low next cycle) else idx <= idx+1 and
//   mem_adr advances next cycle with mem_rd still high. No mem_ready: hold everything.
//  FILL: stall=1, cWrite=1 exactly one cycle, adr<k>=base+k, block<k> stable; next state IDLE.
//  adr0..adr3 always = base+0..3 (no wrap past a 4-aligned boundary; low 2 bits are k).
//  Min latency: miss seen cycle 0; mem_rd cycles 1-4 (mem_ready same cycle); cWrite cycle 5;
//   cycle 6 IDLE, cache hits, stall=0.
//  address/req changes during FETCH/FILL are ignored (base latched); if req is dropped mid-fill
//   the fill still completes. Back-to-back misses: new miss accepted in the cycle after FILL.
//  mem_data captured only on mem_ready in FETCH; mem_ready while mem_rd=0 is ignored.
// CONFIGURATION
//  CACHE_MISS_COUNT_EN defined: miss_count increments by 1 on each IDLE->FETCH transition,
//   saturates at 16'hFFFF, cleared by reset. Not defined: miss_count port absent, no counter logic.
// STRUCTURE
//  Shared package cache_pkg: WORD, ADDRESSL, TAG, ADDRW, BLOCK_WORDS=4, state typedef
//   {IDLE,FETCH,FILL}. Used by cache and this controller.
//  One sub-module: cache_fill_buffer (4xWORD regs, write port idx/data/en, async clear) providing
//   block0..3; FSM, idx counter, address generation stay in cache_fill_controller.
// TESTING
//  1 Reset: rst=0 mid-FETCH (idx=2) -> all outputs 0 immediately, no cWrite afterwards, IDLE.
//  2 Miss, zero-wait memory: address=15'h1235, hit=0 -> mem_adr 0x1234,0x1235,0x1236,0x1237 on
//    cycles 1-4, cWrite on cycle 5 with block<k>=mem word k, stall low cycle 6.
//  3 Wait states: mem_ready low 3 cycles per word -> mem_rd/mem_adr held, 16 fetch cycles, one cWrite.
//  4 Hit: req=1, hit=1 -> stall=0, mem_rd never asserted, cWrite stays 0.
//  5 Address changes to 15'h7FFF mid-FETCH -> fill continues at original base, adr3=base+3.
//  6 CACHE_MISS_COUNT_EN: 3 misses + 2 hits -> miss_count=3; preload 16'hFFFF, miss -> stays 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the direct-mapped cache and its miss-side fill
//   controller: data/address geometry, block size, the fill FSM state type
//   and small helper functions used for address and counter arithmetic.
//
//   Contents:
//     WORD         data word width
//     ADDRESSL     cache index width
//     TAG          tag width
//     ADDRW        full CPU word address width (ADDRESSL + TAG)
//     BLOCK_WORDS  words per cache block
//     fillState_t  fill controller FSM states {IDLE, FETCH, FILL}
//     blockBase()  4-word aligned base of a word address
//     satInc16()   16-bit saturating increment
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int WORD        = 32;
    localparam int ADDRESSL    = 12;
    localparam int TAG         = 3;
    localparam int ADDRW       = ADDRESSL + TAG;
    localparam int BLOCK_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } fillState_t;

    // Block base: clear the word-in-block bits so the fetch starts at word 0.
    function automatic logic [ADDRW-1:0] blockBase(input logic [ADDRW-1:0] addr);
        return {addr[ADDRW-1:2], 2'b00};
    endfunction

    // Counter that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cache_fill_buffer.sv
// ---------------------------------------------------------------------------
// cache_fill_buffer
//   Four word registers that collect one cache block as it arrives from
//   memory. A single write port stores wrData into the register selected by
//   wrIdx when wrEn is high. The asynchronous active-low reset clears every
//   word so an abandoned fetch leaves no stale data behind.
//
//   Ports:
//     clk              in   clock, registers update on posedge
//     rst              in   asynchronous active-low clear
//     wrEn             in   store wrData this cycle
//     wrIdx            in   word-in-block index (0..3)
//     wrData           in   word to store
//     block0..block3   out  stored words, block<k> holds word k
// ---------------------------------------------------------------------------
module cache_fill_buffer
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [1:0]      wrIdx,
    input  logic [WORD-1:0] wrData,
    output logic [WORD-1:0] block0,
    output logic [WORD-1:0] block1,
    output logic [WORD-1:0] block2,
    output logic [WORD-1:0] block3
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block0 <= '0;
            block1 <= '0;
            block2 <= '0;
            block3 <= '0;
        end else if (wrEn) begin
            case (wrIdx)
                2'd0:    block0 <= wrData;
                2'd1:    block1 <= wrData;
                2'd2:    block2 <= wrData;
                default: block3 <= wrData;
            endcase
        end
    end

endmodule

// File: rtl/cache_fill_controller.sv
// ---------------------------------------------------------------------------
// cache_fill_controller
//   Miss-side partner of the direct-mapped cache. When a CPU read misses,
//   the controller fetches the aligned 4-word block from main memory one
//   word at a time, then pulses cWrite for one cycle with adr0..adr3 and
//   block0..block3 so the cache can store the whole block. The CPU is
//   stalled until the refilled block is readable.
//
//   Optional feature (macro CACHE_MISS_COUNT_EN): a 16-bit saturating
//   counter of serviced misses on port miss_count. Without the macro the
//   port and the counter do not exist.
//
//   Ports:
//     clk         in   clock, all state on posedge
//     rst         in   asynchronous active-low reset
//     req         in   CPU read request, held with address until stall==0
//     address     in   CPU word address
//     hit         in   cache hit for address (combinational from the cache)
//     stall       out  CPU must hold its request
//     mem_rd      out  memory read request
//     mem_adr     out  memory word address
//     mem_ready   in   memory word valid on mem_data this cycle
//     mem_data    in   memory read data
//     cWrite      out  one-cycle cache block write strobe
//     adr0..adr3  out  block word addresses base+0..base+3
//     block0..3   out  fetched words, block<k> belongs to adr<k>
//     miss_count  out  misses serviced (CACHE_MISS_COUNT_EN only)
//
//   Memory handshake: a word transfers on a posedge where mem_rd and
//   mem_ready are both high. mem_rd and mem_adr stay stable until that
//   transfer; mem_ready while mem_rd is low carries no meaning and is
//   ignored.
// ---------------------------------------------------------------------------
module cache_fill_controller
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [ADDRW-1:0] address,
    input  logic             hit,
    output logic             stall,
    output logic             mem_rd,
    output logic [ADDRW-1:0] mem_adr,
    input  logic             mem_ready,
    input  logic [WORD-1:0]  mem_data,
    output logic             cWrite,
    output logic [ADDRW-1:0] adr0,
    output logic [ADDRW-1:0] adr1,
    output logic [ADDRW-1:0] adr2,
    output logic [ADDRW-1:0] adr3,
    output logic [WORD-1:0]  block0,
    output logic [WORD-1:0]  block1,
    output logic [WORD-1:0]  block2,
    output logic [WORD-1:0]  block3
`ifdef CACHE_MISS_COUNT_EN
    ,
    output logic [15:0]      miss_count
`endif
);

    fillState_t       state;
    logic [1:0]       idx;
    logic [ADDRW-1:0] base;
    logic             missSeen;
    logic             wordAccepted;

    // A miss is only acted on while idle; during FETCH/FILL the latched base
    // is authoritative and req/address are not looked at.
    assign missSeen     = (state == IDLE) && req && !hit;
    assign wordAccepted = (state == FETCH) && mem_ready;

    // Idle: stall tracks the miss combinationally so the CPU holds on the
    // very cycle it misses. Busy: always stall until the fill has landed.
    assign stall = (state != IDLE) || (req && !hit);

    // base is 4-aligned, so the low two bits are simply the word number.
    assign adr0 = {base[ADDRW-1:2], 2'd0};
    assign adr1 = {base[ADDRW-1:2], 2'd1};
    assign adr2 = {base[ADDRW-1:2], 2'd2};
    assign adr3 = {base[ADDRW-1:2], 2'd3};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            base    <= '0;
            mem_rd  <= 1'b0;
            mem_adr <= '0;
            cWrite  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cWrite <= 1'b0;
                    if (missSeen) begin
                        base    <= blockBase(address);
                        mem_adr <= blockBase(address);
                        idx     <= 2'd0;
                        mem_rd  <= 1'b1;
                        state   <= FETCH;
                    end
                end

                FETCH: begin
                    if (mem_ready) begin
                        if (idx == 2'd3) begin
                            // Last word arrives this edge; the buffer holds
                            // all four words during FILL.
                            mem_rd <= 1'b0;
                            cWrite <= 1'b1;
                            state  <= FILL;
                        end else begin
                            idx     <= idx + 2'd1;
                            mem_adr <= {base[ADDRW-1:2], idx + 2'd1};
                        end
                    end
                end

                FILL: begin
                    cWrite <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    mem_rd <= 1'b0;
                    cWrite <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    cache_fill_buffer u_fillBuffer (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wordAccepted),
        .wrIdx  (idx),
        .wrData (mem_data),
        .block0 (block0),
        .block1 (block1),
        .block2 (block2),
        .block3 (block3)
    );

`ifdef CACHE_MISS_COUNT_EN
    // Counts accepted misses (IDLE->FETCH), sticking at 16'hFFFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count <= 16'd0;
        end else if (missSeen) begin
            miss_count <= satInc16(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_controller
//   Directed bench for cache_fill_controller. Inputs are driven on the
//   falling clock edge, outputs are sampled 1 time unit later. Memory words
//   are 32'hD000_0000 | word address, so every expected block value is known
//   from the address alone. Define CACHE_MISS_COUNT_EN to also exercise the
//   miss counter.
// ---------------------------------------------------------------------------
module tb_cache_fill_controller;
    import cache_pkg::*;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [ADDRW-1:0] address;
    logic             hit;
    logic             stall;
    logic             mem_rd;
    logic [ADDRW-1:0] mem_adr;
    logic             mem_ready;
    logic [WORD-1:0]  mem_data;
    logic             cWrite;
    logic [ADDRW-1:0] adr0, adr1, adr2, adr3;
    logic [WORD-1:0]  block0, block1, block2, block3;
`ifdef CACHE_MISS_COUNT_EN
    logic [15:0]      miss_count;
`endif

    always #5 clk = ~clk;

    cache_fill_controller dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .address    (address),
        .hit        (hit),
        .stall      (stall),
        .mem_rd     (mem_rd),
        .mem_adr    (mem_adr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .cWrite     (cWrite),
        .adr0       (adr0),
        .adr1       (adr1),
        .adr2       (adr2),
        .adr3       (adr3),
        .block0     (block0),
        .block1     (block1),
        .block2     (block2),
        .block3     (block3)
`ifdef CACHE_MISS_COUNT_EN
        ,
        .miss_count (miss_count)
`endif
    );

    logic [WORD-1:0]  blk [4];
    logic [ADDRW-1:0] adr [4];
    assign blk[0] = block0;
    assign blk[1] = block1;
    assign blk[2] = block2;
    assign blk[3] = block3;
    assign adr[0] = adr0;
    assign adr[1] = adr1;
    assign adr[2] = adr2;
    assign adr[3] = adr3;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          nChecks = 0;
    int          nFails  = 0;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [ADDRW-1:0] a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    // ---------------- driver tasks ----------------
    // mode 0: plain miss; mode 1: address jumps to 7FFF after the miss is
    // taken; mode 2: req dropped once fetching has begun.
    task automatic fetchBlock(input logic [ADDRW-1:0] addr, input int waits, input int mode);
        logic [ADDRW-1:0] base;
        logic [31:0]      w;
        base = {addr[ADDRW-1:2], 2'b00};
        @(negedge clk);
        req       = 1'b1;
        address   = addr;
        hit       = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkEq("idle_stall", 32'(stall), 32'd1);
        checkEq("idle_no_rd", 32'(mem_rd), 32'd0);
        for (int k = 0; k < 4; k++) begin
            for (int wt = 0; wt <= waits; wt++) begin
                @(negedge clk);
                if (mode == 1) address = 15'h7FFF;
                if (mode == 2) req = 1'b0;
                #1;
                checkEq("fetch_rd", 32'(mem_rd), 32'd1);
                checkEq("fetch_adr", 32'(mem_adr), 32'(base) + 32'(k));
                checkEq("fetch_stall", 32'(stall), 32'd1);
                checkEq("fetch_no_cw", 32'(cWrite), 32'd0);
                if (wt == waits) begin
                    w         = memWord(base + 15'(k));
                    mem_data  = w;
                    mem_ready = 1'b1;
                    exp_q.push_back(w);
                end else begin
                    mem_data  = $urandom;
                    mem_ready = 1'b0;
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data  = $urandom;
        #1;
        checkEq("fill_cw", 32'(cWrite), 32'd1);
        checkEq("fill_rd_low", 32'(mem_rd), 32'd0);
        checkEq("fill_stall", 32'(stall), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkEq("fill_adr", 32'(adr[k]), 32'(base) + 32'(k));
            if (exp_q.size() > 0) checkEq("fill_block", blk[k], exp_q.pop_front());
            else checkEq("fill_block_missing", 32'd0, 32'd1);
        end
        // The refilled block now hits in the cache.
        hit = 1'b1;
        @(negedge clk);
        #1;
        checkEq("after_cw_low", 32'(cWrite), 32'd0);
        checkEq("after_stall_low", 32'(stall), 32'd0);
        checkEq("after_rd_low", 32'(mem_rd), 32'd0);
        req = 1'b0;
        hit = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        req       = 1'b0;
        address   = '0;
        hit       = 1'b0;
        mem_ready = 1'b0;
        mem_data  = '0;
        #1;
        checkEq("rst_stall", 32'(stall), 32'd0);
        checkEq("rst_rd", 32'(mem_rd), 32'd0);
        checkEq("rst_adr", 32'(mem_adr), 32'd0);
        checkEq("rst_cw", 32'(cWrite), 32'd0);
        checkEq("rst_block3", block3, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Zero-wait miss: mem_adr 1234..1237 on cycles 1-4, cWrite cycle 5.
        fetchBlock(15'h1235, 0, 0);

        // Three wait states per word: 16 fetch cycles, one cWrite.
        fetchBlock(15'h0ABC, 3, 0);

        // Address moves to 7FFF mid-fetch: original base kept.
        fetchBlock(15'h2346, 0, 1);

        // req dropped mid-fill: the fill still completes.
        fetchBlock(15'h5007, 1, 2);

        // Hit: no stall, no memory read, no cache write.
        @(negedge clk);
        req     = 1'b1;
        hit     = 1'b1;
        address = 15'h0444;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'(c & 1);
            #1;
            checkEq("hit_stall", 32'(stall), 32'd0);
            checkEq("hit_rd", 32'(mem_rd), 32'd0);
            checkEq("hit_cw", 32'(cWrite), 32'd0);
            @(negedge clk);
        end
        req       = 1'b0;
        hit       = 1'b0;
        mem_ready = 1'b0;

        // Reset while fetching word 2: everything clears, no cWrite later.
        @(negedge clk);
        req     = 1'b1;
        hit     = 1'b0;
        address = 15'h0A11;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_data  = memWord(15'h0A10 + 15'(k));
            mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checkEq("pre_rst_adr", 32'(mem_adr), 32'h0A12);
        #1;
        rst = 1'b0;
        req = 1'b0;
        #1;
        checkEq("midrst_rd", 32'(mem_rd), 32'd0);
        checkEq("midrst_adr", 32'(mem_adr), 32'd0);
        checkEq("midrst_cw", 32'(cWrite), 32'd0);
        checkEq("midrst_stall", 32'(stall), 32'd0);
        checkEq("midrst_block0", block0, 32'd0);
        checkEq("midrst_block1", block1, 32'd0);
        checkEq("midrst_adr0", 32'(adr0), 32'd0);
        checkEq("midrst_adr3", 32'(adr3), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_data  = $urandom;
            @(negedge clk);
            #1;
            checkEq("postrst_cw", 32'(cWrite), 32'd0);
            checkEq("postrst_rd", 32'(mem_rd), 32'd0);
        end
        mem_ready = 1'b0;

`ifdef CACHE_MISS_COUNT_EN
        pulseReset();
        #1;
        checkEq("mc_reset", 32'(miss_count), 32'd0);
        fetchBlock(15'h0100, 0, 0);
        fetchBlock(15'h0205, 0, 0);
        @(negedge clk);
        req = 1'b1;
        hit = 1'b1;
        repeat (2) @(negedge clk);
        req = 1'b0;
        hit = 1'b0;
        fetchBlock(15'h030A, 1, 0);
        #1;
        checkEq("mc_three", 32'(miss_count), 32'd3);
        @(negedge clk);
        force dut.miss_count = 16'hFFFF;
        @(negedge clk);
        release dut.miss_count;
        fetchBlock(15'h0410, 0, 0);
        #1;
        checkEq("mc_saturate", 32'(miss_count), 32'h0000_FFFF);
`else
        pulseReset();
        #1;
        checkEq("rst_again_rd", 32'(mem_rd), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
        $finish;
    end

    // Hard time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish before %0t", $time);
        nFails++;
        $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
        $fatal(1, "timeout");
    end

endmodule
